lvc_deglitch_bank: RTL
======================

# lvc_deglitch_bank

Parametrised, clocked successor to the single-gate inverter model: a bank of WIDTH independent channels, each with an input synchroniser, a cycle-counted inertial glitch filter and an optional per-channel inversion. A channel's output changes only after its input has held a new level for FILTER_CYCLES consecutive clocks, the synchronous counterpart of the inverter's delay-based glitch rejection. It sits between asynchronous board-level signals (switches, external strobes, 74-series outputs) and the clocked lmarv-1 simulation logic. It also reports level edges and rejected glitches as one-cycle pulses.

## Interface
- WIDTH, 4: number of channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (1..3).
- FILTER_CYCLES, 3: consecutive differing samples required to accept a new level (≥1).
- INVERT, {WIDTH{1'b0}}: per-channel mask; bit set gives y = NOT filtered level (74LVC04 mode).
- RESET_LEVEL, {WIDTH{1'b0}}: filtered level loaded on reset.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  WIDTH  raw channel inputs, asynchronous to clk.
- y  out  WIDTH  filtered, optionally inverted levels (registered).
- rise  out  WIDTH  one-cycle pulse when the filtered level goes 0→1 (pre-inversion).
- fall  out  WIDTH  one-cycle pulse when the filtered level goes 1→0 (pre-inversion).
- glitch  out  WIDTH  one-cycle pulse when a pending change is abandoned.

## Operation
- Per channel: sync chain sync[0..S-1], sync[0] ← a; s = sync[S-1]; filtered level f; counter cnt, width max(1, $clog2(FILTER_CYCLES)).
- Each rising edge, per channel:
  - s == f and cnt == 0: hold; no pulses.
  - s == f and cnt != 0: cnt ← 0; glitch pulse.
  - s != f and cnt == FILTER_CYCLES-1: f ← s; cnt ← 0; rise (s=1) or fall (s=0) pulse.
  - s != f otherwise: cnt ← cnt+1.
- y = f ^ INVERT, held in a register and updated on the same edge as f.
- Channels are fully independent; simultaneous changes on any subset are processed in parallel with no interaction.
- rise, fall and glitch are mutually exclusive per channel per cycle.
- FILTER_CYCLES = 1: any change reaching s is accepted on the next edge; glitch never asserts.
- Counter never exceeds FILTER_CYCLES-1; no wrap-around.
- Reset (asynchronous, any time including mid-count): sync chains ← RESET_LEVEL, f ← RESET_LEVEL, cnt ← 0, y ← RESET_LEVEL ^ INVERT, rise = fall = glitch = 0. Pending changes are discarded without a glitch pulse.
- First edge after reset release: normal operation. An input differing from RESET_LEVEL is then filtered like any other change.

## Timing
- Input a changes before edge E0, with setup met at E0.
- sync[0] updates at E0; s updates at E(S-1).
- Count runs at E(S) .. E(S+F-2); f, y and rise/fall update at E(S+F-1).
- Total latency is SYNC_STAGES + FILTER_CYCLES edges, counting E0. Default: 5 edges.
- A pulse sampled high on P consecutive edges passes iff P ≥ FILTER_CYCLES. Otherwise glitch pulses at edge E(S+P), and y is unchanged.
- Pulses are high for exactly one clock after the edge that sets them.
- Sampling an input that changes inside the setup window may resolve to either level. This is tolerated by design; the simulation model treats it as the sampled value.

## Structure
- Shared package lmarv_sim_pkg holds a clog2-based counter-width function, max(1, $clog2(n)), used by this and future counted blocks.
- Sub-module deglitch_channel implements one channel (sync chain, counter, f, y bit, pulses). It takes SYNC_STAGES, FILTER_CYCLES, INVERT_BIT and RESET_BIT parameters.
- lvc_deglitch_bank instantiates WIDTH copies of deglitch_channel via generate and slices the INVERT and RESET_LEVEL masks.

## Test plan
Defaults unless noted: WIDTH=4, S=2, F=3, INVERT=4'b0101, RESET_LEVEL=4'b0000.
- Reset asserted with a=4'b1111, clk running → y=4'b0101 immediately; rise, fall and glitch all 0. Values hold while rst=1.
- a[1] 0→1 before E0 and held → y[1]=1 from E4 (5th edge); rise[1] high for exactly one cycle after E4; other bits unchanged.
- a[0] high for 2 sampled edges → y[0] stays 1, no rise[0]; glitch[0] pulses once, after E4.
- a[2] high for exactly 3 sampled edges → y[2] 1→0 after E4 and back to 1 three edges later; one rise[2] and one fall[2] pulse; no glitch.
- a=4'b1111 all at once, then rst pulsed at E3 (mid-count) → no channel output changes and no pulses. After release with a still 4'b1111, y=4'b1010 five edges later, with rise=4'b1111 for one cycle.
- Build with S=1, F=1 → y tracks a with 2-edge latency; a 1-cycle pulse passes; glitch stays 0 throughout.

Source files
------------

// File: rtl/lmarv_sim_pkg.sv
// Shared helpers for the clocked lmarv-1 simulation blocks.
package lmarv_sim_pkg;

  // Counter width for a count that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deglitch_channel.sv
// One deglitch channel: synchroniser chain, inertial filter counter,
// registered (optionally inverted) level and edge/glitch pulses.
module deglitch_channel
  import lmarv_sim_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 3,
  parameter logic INVERT_BIT    = 1'b0,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic y,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   f_q, f_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   y_q, y_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = a;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // A pending change is committed once s has differed from f for FILTER_CYCLES edges.
  always_comb begin
    f_d      = f_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (s == f_q) begin
      if (cnt_q != '0) begin
        cnt_d    = '0;
        glitch_d = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      f_d    = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    y_d = f_d ^ INVERT_BIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_BIT}};
      f_q      <= RESET_BIT;
      cnt_q    <= '0;
      y_q      <= RESET_BIT ^ INVERT_BIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      f_q      <= f_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign y      = y_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign glitch = glitch_q;

endmodule

// File: rtl/lvc_deglitch_bank.sv
// Bank of WIDTH independent deglitch channels bridging asynchronous board
// signals into the clocked simulation domain.
module lvc_deglitch_bank
  import lmarv_sim_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] INVERT        = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RESET_LEVEL   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    deglitch_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .INVERT_BIT   (INVERT[i]),
      .RESET_BIT    (RESET_LEVEL[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .a     (a[i]),
      .y     (y[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .glitch(glitch[i])
    );
  end

endmodule
